fetch_queue: RTL and testbench

Parametrised instruction prefetch queue between instruction memory and the decode stage of the pipelined 16-bit CPU. It generates sequential fetch addresses and buffers up to DEPTH returned instruction words with their PCs. Decode consumes them through a valid/ready handshake. A redirect (taken branch/jump from execute) flushes all buffered and in-flight fetches and restarts at a new PC.

---
 rtl/fetch_queue.sv | 118 +++++++++++
 tb/tb_fetch_queue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue
//
// Instruction prefetch queue that sits between instruction memory and decode.
// It issues one sequential fetch per cycle while there is room, buffers up to
// DEPTH returned words together with their PCs, and hands them to decode in
// order. A redirect flushes everything and restarts fetching at a new PC.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low; low clears all state
//   o_pc_addr      current fetch address (registered fetch_pc)
//   o_pc_rd        fetch request this cycle
//   i_pc_rddata    memory data, valid exactly one cycle after o_pc_rd
//   i_redirect     flush all buffered and in-flight fetches
//   i_redirect_pc  restart address, sampled while i_redirect is high
//   o_valid        head entry valid
//   o_instr        head instruction word
//   o_pc           address of the head instruction
//   i_ready        decode accepts the head entry
//   o_count        number of occupied entries
//
// Handshake: the head entry moves to decode on every rising edge where
// o_valid and i_ready are both high. o_valid never depends on i_ready, and
// o_pc_rd never depends on i_ready either, so a pop does not open a slot for a
// fetch request in the same cycle.

module fetch_queue #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [ADDR_W-1:0]          o_pc_addr,
  output logic                       o_pc_rd,
  input  logic [DATA_W-1:0]          i_pc_rddata,
  input  logic                       i_redirect,
  input  logic [ADDR_W-1:0]          i_redirect_pc,
  output logic                       o_valid,
  output logic [DATA_W-1:0]          o_instr,
  output logic [ADDR_W-1:0]          o_pc,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] fetch_pc;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem    [DEPTH];

  // Occupancy including the outstanding fetch; one extra bit so that
  // count + inflight cannot wrap.
  logic [CNT_W:0] occupied;
  logic           push;
  logic           pop;

  assign occupied = {1'b0, count} + (CNT_W+1)'(inflight);

  assign o_pc_rd   = reset && !i_redirect && (occupied < (CNT_W+1)'(DEPTH));
  assign o_valid   = (count != '0) && !i_redirect;
  assign o_pc_addr = fetch_pc;
  assign o_instr   = instr_mem[rd_ptr];
  assign o_pc      = pc_mem[rd_ptr];
  assign o_count   = count;

  // A return is only accepted when no redirect is flushing this edge.
  assign push = inflight && !i_redirect;
  assign pop  = o_valid && i_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (i_redirect) begin
      // Redirect wins over everything: drop buffered and in-flight words.
      fetch_pc <= i_redirect_pc;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= o_pc_rd;
      if (o_pc_rd) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + ADDR_W'(1);
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; contents are only observed while counted.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      instr_mem[wr_ptr] <= i_pc_rddata;
      pc_mem[wr_ptr]    <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (RESET_PC = 0) ----------------
  logic [15:0] o_pc_addr, i_pc_rddata, i_redirect_pc, o_instr, o_pc;
  logic        o_pc_rd, i_redirect, o_valid, i_ready;
  logic [2:0]  o_count;

  fetch_queue #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset),
    .o_pc_addr(o_pc_addr), .o_pc_rd(o_pc_rd), .i_pc_rddata(i_pc_rddata),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc),
    .i_ready(i_ready), .o_count(o_count)
  );

  // ---------------- second DUT (RESET_PC = 0xFFFE, wrap) ----------------
  logic [15:0] o_pc_addr2, i_pc_rddata2, redir_pc2, o_instr2, o_pc2;
  logic        o_pc_rd2, redir2, o_valid2;
  logic [2:0]  o_count2;

  fetch_queue #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .RESET_PC(16'hFFFE)) dut2 (
    .clk(clk), .reset(reset),
    .o_pc_addr(o_pc_addr2), .o_pc_rd(o_pc_rd2), .i_pc_rddata(i_pc_rddata2),
    .i_redirect(redir2), .i_redirect_pc(redir_pc2),
    .o_valid(o_valid2), .o_instr(o_instr2), .o_pc(o_pc2),
    .i_ready(i_ready), .o_count(o_count2)
  );

  // ---------------- scoreboard / model state ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];      // PCs issued and not yet popped (buffered + in flight)
  logic [15:0] m_fetch;
  int          m_count;
  logic        m_inflight;
  logic [15:0] exp2_pc;       // next PC expected from the wrap instance
  logic        mem_pend, mem2_pend;
  logic [15:0] mem_addr, mem2_addr;

  // values sampled in the latest step, used by the vector table
  logic        s_rd, s_valid;
  logic [15:0] s_addr, s_pc;
  int          s_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fetch    = 16'h0000;
    m_count    = 0;
    m_inflight = 1'b0;
    exp_q.delete();
    exp2_pc    = 16'hFFFE;
    mem_pend   = 1'b0;
    mem2_pend  = 1'b0;
    mem_addr   = 16'h0000;
    mem2_addr  = 16'h0000;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_pc_rd",    32'(o_pc_rd),    32'd0);
    chk("rst_valid",    32'(o_valid),    32'd0);
    chk("rst_count",    32'(o_count),    32'd0);
    chk("rst_pc_addr",  32'(o_pc_addr),  32'h0000);
    chk("rst_pc_addr2", 32'(o_pc_addr2), 32'hFFFE);
    chk("rst_valid2",   32'(o_valid2),   32'd0);
  endtask

  // ---------------- driver: one cycle, entered and left at a negedge -------
  task automatic step(input logic ready, input logic redir, input logic [15:0] rpc);
    logic exp_rd, exp_v, pop;
    i_ready       = ready;
    i_redirect    = redir;
    i_redirect_pc = rpc;
    i_pc_rddata   = mem_pend  ? (mem_addr  ^ 16'hA000) : 16'($urandom);
    i_pc_rddata2  = mem2_pend ? (mem2_addr ^ 16'hA000) : 16'h5555;
    #1;
    exp_rd = !redir && ((m_count + int'(m_inflight)) < DEPTH);
    exp_v  = (m_count != 0) && !redir;
    chk("pc_rd",   32'(o_pc_rd),   32'(exp_rd));
    chk("pc_addr", 32'(o_pc_addr), 32'(m_fetch));
    chk("count",   32'(o_count),   32'(m_count));
    chk("valid",   32'(o_valid),   32'(exp_v));
    pop = exp_v && ready;
    if (pop) begin
      chk("head_pc",    32'(o_pc),    32'(exp_q[0]));
      chk("head_instr", 32'(o_instr), 32'(exp_q[0] ^ 16'hA000));
      void'(exp_q.pop_front());
    end
    if (o_valid2 && ready) begin
      chk("wrap_pc",    32'(o_pc2),    32'(exp2_pc));
      chk("wrap_instr", 32'(o_instr2), 32'(exp2_pc ^ 16'hA000));
      exp2_pc = exp2_pc + 16'd1;
    end
    s_rd = o_pc_rd; s_addr = o_pc_addr; s_valid = o_valid; s_pc = o_pc; s_count = int'(o_count);
    // advance model across the coming edge
    if (redir) begin
      exp_q.delete();
      m_count    = 0;
      m_inflight = 1'b0;
      m_fetch    = rpc;
    end else begin
      m_count = m_count + int'(m_inflight) - int'(pop);
      if (exp_rd) begin
        exp_q.push_back(m_fetch);
        m_fetch = m_fetch + 16'd1;
      end
      m_inflight = exp_rd;
    end
    // memory: returns data one cycle after each request
    mem_pend  = o_pc_rd;  mem_addr  = o_pc_addr;
    mem2_pend = o_pc_rd2; mem2_addr = o_pc_addr2;
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        ready;
    logic        redir;
    logic [15:0] rpc;
    logic        rd;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] pc;
    int          count;
  } vec_t;

  vec_t tbl[17];

  initial begin
    // fill, starting on the first cycle after reset release
    tbl[0]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 0};
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 16'h0000, 0};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'h0000, 1};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b1, 16'h0000, 2};
    tbl[4]  = '{1'b0, 1'b1, 16'h0040, 1'b0, 16'h0004, 1'b0, 16'h0000, 3}; // count=3 + 1 in flight
    tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0, 16'h0000, 0};
    tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0041, 1'b0, 16'h0000, 0};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0042, 1'b1, 16'h0040, 1};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0043, 1'b1, 16'h0040, 2};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0044, 1'b1, 16'h0040, 3};
    tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0044, 1'b1, 16'h0040, 4};
    tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0044, 1'b1, 16'h0040, 4};
    tbl[12] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0044, 1'b1, 16'h0040, 4}; // pop does not free a slot this cycle
    tbl[13] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0044, 1'b1, 16'h0041, 3};
    tbl[14] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0045, 1'b1, 16'h0042, 2};
    tbl[15] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0046, 1'b1, 16'h0043, 2};
    tbl[16] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0047, 1'b1, 16'h0044, 2};

    reset         = 1'b0;
    i_ready       = 1'b0;
    i_redirect    = 1'b0;
    i_redirect_pc = 16'h0000;
    i_pc_rddata   = 16'h0000;
    i_pc_rddata2  = 16'h0000;
    redir2        = 1'b0;
    redir_pc2     = 16'h0000;
    model_reset();

    repeat (3) @(negedge clk);
    chk_reset_outputs();

    // release and run the vector table (full queue, redirect with data in flight)
    reset = 1'b1;
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].ready, tbl[i].redir, tbl[i].rpc);
      chk($sformatf("tbl%0d_pc_rd", i),   32'(s_rd),    32'(tbl[i].rd));
      chk($sformatf("tbl%0d_pc_addr", i), 32'(s_addr),  32'(tbl[i].addr));
      chk($sformatf("tbl%0d_valid", i),   32'(s_valid), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d_count", i),   32'(s_count), 32'(tbl[i].count));
      if (tbl[i].valid)
        chk($sformatf("tbl%0d_pc", i), 32'(s_pc), 32'(tbl[i].pc));
    end

    // sustained stream, one instruction per cycle
    repeat (12) begin
      step(1'b1, 1'b0, 16'h0000);
      chk("stream_valid", 32'(s_valid), 32'd1);
    end

    // reset asserted while a return is on the bus
    chk("pre_reset_pending", 32'(mem_pend), 32'd1);
    i_pc_rddata = mem_addr ^ 16'hA000;
    reset = 1'b0;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    chk_reset_outputs();
    reset = 1'b1;
    model_reset();
    // stale data presented right after release must be ignored
    mem_pend  = 1'b1; mem_addr  = 16'h0077;
    mem2_pend = 1'b1; mem2_addr = 16'h0077;
    step(1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 16'h0000);
    chk("post_reset_first_pc", 32'(s_pc), 32'h0000);
    repeat (5) step(1'b1, 1'b0, 16'h0000);

    // random ready with collisions and occasional redirects
    for (int c = 0; c < 1000; c++) begin
      logic r, d;
      r = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 63) == 0);
      step(r, d, 16'($urandom));
      chk("count_max", 32'(s_count <= DEPTH), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
